// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared types and helpers for the single-CS SPI master
package spi_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRANSFER,
        CS_INACTIVE
    } state_t;

    function automatic logic spi_cpol(input int mode);
        return mode[1];
    endfunction

    function automatic logic spi_cpha(input int mode);
        return mode[0];
    endfunction

    // Width able to hold 0..n inclusive, never narrower than one bit.
    function automatic int spi_count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_master_single_cs_if.sv
// rtl/spi_master_single_cs_if.sv - host-side byte handshake bus of the SPI master
interface spi_master_single_cs_if #(
    parameter int CW = 2
);
    logic [CW-1:0] i_TX_Count;
    logic [7:0]    i_TX_Byte;
    logic          i_TX_DV;
    logic          o_TX_Ready;
    logic [CW-1:0] o_RX_Count;
    logic          o_RX_DV;
    logic [7:0]    o_RX_Byte;

    modport master (
        output i_TX_Count, i_TX_Byte, i_TX_DV,
        input  o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte
    );

    modport slave (
        input  i_TX_Count, i_TX_Byte, i_TX_DV,
        output o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte
    );
endinterface

// File: rtl/spi_master_byte.sv
// rtl/spi_master_byte.sv - single-byte SPI shift engine, MSB first, all four modes
module spi_master_byte
    import spi_master_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_SPI_Clk,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_MOSI
);
    localparam logic CPOL = spi_cpol(SPI_MODE);
    localparam logic CPHA = spi_cpha(SPI_MODE);
    localparam int   HW   = $clog2(CLKS_PER_HALF_BIT);

    logic [HW-1:0] half_cnt;
    logic [4:0]    edge_cnt;
    logic [7:0]    tx_shift;
    logic [7:0]    rx_shift;
    logic          edge_now;
    logic          leading;
    logic          sample_now;
    logic          shift_now;

    // edge_cnt counts down from 16; even values mark leading edges.
    always_comb begin
        edge_now   = (edge_cnt != 5'd0) && (half_cnt == HW'(CLKS_PER_HALF_BIT - 1));
        leading    = ~edge_cnt[0];
        sample_now = edge_now && (leading != CPHA);
        shift_now  = edge_now && (leading == CPHA) && (CPHA || (edge_cnt != 5'd1));
        o_TX_Ready = (edge_cnt == 5'd0);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            half_cnt   <= '0;
            edge_cnt   <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            o_RX_DV    <= 1'b0;
            o_RX_Byte  <= '0;
            o_SPI_Clk  <= CPOL;
            o_SPI_MOSI <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;
            if (i_TX_DV && (edge_cnt == 5'd0)) begin
                edge_cnt <= 5'd16;
                half_cnt <= '0;
                // With CPHA=0 the first bit must already be on the wire before the first edge.
                if (!CPHA) begin
                    o_SPI_MOSI <= i_TX_Byte[7];
                    tx_shift   <= {i_TX_Byte[6:0], 1'b0};
                end else begin
                    tx_shift   <= i_TX_Byte;
                end
            end else if (edge_cnt != 5'd0) begin
                if (edge_now) begin
                    half_cnt  <= '0;
                    edge_cnt  <= edge_cnt - 5'd1;
                    o_SPI_Clk <= ~o_SPI_Clk;
                end else begin
                    half_cnt  <= half_cnt + HW'(1);
                end
                if (shift_now) begin
                    o_SPI_MOSI <= tx_shift[7];
                    tx_shift   <= {tx_shift[6:0], 1'b0};
                end
                if (sample_now) begin
                    rx_shift <= {rx_shift[6:0], i_SPI_MISO};
                    if (edge_cnt == (CPHA ? 5'd1 : 5'd2)) begin
                        o_RX_Byte <= {rx_shift[6:0], i_SPI_MISO};
                        o_RX_DV   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi_master_single_cs.sv
// rtl/spi_master_single_cs.sv - SPI master with automatic active-low chip select and burst control
module spi_master_single_cs
    import spi_master_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int MAX_BYTES_PER_CS  = 2,
    parameter int CS_INACTIVE_CLKS  = 1
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    spi_master_single_cs_if.slave  bus,
    output logic                   o_SPI_Clk,
    input  logic                   i_SPI_MISO,
    output logic                   o_SPI_MOSI,
    output logic                   o_SPI_CS_n
);
    localparam int CW = spi_count_width(MAX_BYTES_PER_CS);
    localparam int GW = spi_count_width(CS_INACTIVE_CLKS);

    state_t        state_q, state_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          cs_n_q, cs_n_d;
    logic [CW-1:0] burst_len;
    logic [CW-1:0] rx_count;
    logic          can_accept;
    logic          eng_start;
    logic          eng_ready;
    logic          eng_rx_dv;

    spi_master_byte #(
        .SPI_MODE          (SPI_MODE),
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
    ) u_byte (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_TX_Byte  (bus.i_TX_Byte),
        .i_TX_DV    (eng_start),
        .o_TX_Ready (eng_ready),
        .o_RX_DV    (eng_rx_dv),
        .o_RX_Byte  (bus.o_RX_Byte),
        .o_SPI_Clk  (o_SPI_Clk),
        .i_SPI_MISO (i_SPI_MISO),
        .o_SPI_MOSI (o_SPI_MOSI)
    );

    always_comb begin
        if (bus.i_TX_Count == '0) begin
            burst_len = CW'(1);
        end else if (bus.i_TX_Count > CW'(MAX_BYTES_PER_CS)) begin
            burst_len = CW'(MAX_BYTES_PER_CS);
        end else begin
            burst_len = bus.i_TX_Count;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            gap_q       <= '0;
            cs_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            gap_q       <= gap_d;
            cs_n_q      <= cs_n_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        gap_d       = gap_q;
        cs_n_d      = cs_n_q;
        eng_start   = 1'b0;
        can_accept  = (state_q == IDLE) ||
                      ((state_q == TRANSFER) && eng_ready && (remaining_q != '0));
        case (state_q)
            IDLE: begin
                if (bus.i_TX_DV) begin
                    eng_start   = 1'b1;
                    remaining_d = burst_len - CW'(1);
                    cs_n_d      = 1'b0;
                    state_d     = TRANSFER;
                end
            end
            TRANSFER: begin
                // CS is held low for as long as the host takes to supply the next byte.
                if (eng_ready) begin
                    if (remaining_q != '0) begin
                        if (bus.i_TX_DV) begin
                            eng_start   = 1'b1;
                            remaining_d = remaining_q - CW'(1);
                        end
                    end else begin
                        cs_n_d  = 1'b1;
                        gap_d   = GW'(CS_INACTIVE_CLKS);
                        state_d = CS_INACTIVE;
                    end
                end
            end
            CS_INACTIVE: begin
                if (gap_q <= GW'(1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        bus.o_TX_Ready = can_accept && !bus.i_TX_DV;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst || cs_n_q) begin
            rx_count <= '0;
        end else if (eng_rx_dv) begin
            rx_count <= rx_count + CW'(1);
        end
    end

    assign bus.o_RX_Count = rx_count;
    assign bus.o_RX_DV    = eng_rx_dv;
    assign o_SPI_CS_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_single_cs.sv
// tb/tb_spi_master_single_cs.sv - directed loopback bench for spi_master_single_cs in modes 0 and 3
module tb_spi_master_single_cs;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       tx_dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic [1:0] tx_count = 2'd0;

    logic sclk0, mosi0, cs0, sclk3, mosi3, cs3;

    spi_master_single_cs_if #(.CW(2)) bus0 ();
    spi_master_single_cs_if #(.CW(2)) bus3 ();

    assign bus0.i_TX_DV    = tx_dv & ~sel;
    assign bus0.i_TX_Byte  = tx_byte;
    assign bus0.i_TX_Count = tx_count;
    assign bus3.i_TX_DV    = tx_dv & sel;
    assign bus3.i_TX_Byte  = tx_byte;
    assign bus3.i_TX_Count = tx_count;

    spi_master_single_cs #(
        .SPI_MODE(0), .CLKS_PER_HALF_BIT(4), .MAX_BYTES_PER_CS(2), .CS_INACTIVE_CLKS(10)
    ) u_dut0 (
        .i_Clk(clk), .i_Rst(rst), .bus(bus0.slave),
        .o_SPI_Clk(sclk0), .i_SPI_MISO(mosi0), .o_SPI_MOSI(mosi0), .o_SPI_CS_n(cs0)
    );

    spi_master_single_cs #(
        .SPI_MODE(3), .CLKS_PER_HALF_BIT(4), .MAX_BYTES_PER_CS(2), .CS_INACTIVE_CLKS(10)
    ) u_dut3 (
        .i_Clk(clk), .i_Rst(rst), .bus(bus3.slave),
        .o_SPI_Clk(sclk3), .i_SPI_MISO(mosi3), .o_SPI_MOSI(mosi3), .o_SPI_CS_n(cs3)
    );

    always #5 clk = ~clk;

    logic       s_ready, s_cs, s_clk, s_mosi, s_rx_dv;
    logic [7:0] s_rx_byte;
    logic [1:0] s_rx_count;
    assign s_ready    = sel ? bus3.o_TX_Ready : bus0.o_TX_Ready;
    assign s_cs       = sel ? cs3 : cs0;
    assign s_clk      = sel ? sclk3 : sclk0;
    assign s_mosi     = sel ? mosi3 : mosi0;
    assign s_rx_dv    = sel ? bus3.o_RX_DV : bus0.o_RX_DV;
    assign s_rx_byte  = sel ? bus3.o_RX_Byte : bus0.o_RX_Byte;
    assign s_rx_count = sel ? bus3.o_RX_Count : bus0.o_RX_Count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  rx_q[$];
    logic [1:0]  rxc_q[$];
    int          clk_rises, cs_rises, mosi_bad;
    logic [1:0]  max_rxc;
    logic [15:0] mosi_bits;
    logic        prev_clk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor samples 1 time unit after each rising edge; stimulus runs on falling edges.
    always @(posedge clk) begin
        #1;
        if (s_rx_dv) begin
            rx_q.push_back(s_rx_byte);
            rxc_q.push_back(s_rx_count);
        end
        if (!prev_clk && s_clk && !s_cs) begin
            clk_rises++;
            mosi_bits = {mosi_bits[14:0], s_mosi};
        end
        if (!prev_cs && s_cs) cs_rises++;
        if (s_rx_count > max_rxc) max_rxc = s_rx_count;
        if ((s_mosi != prev_mosi) && !(prev_clk && !s_clk)) mosi_bad++;
        prev_clk  = s_clk;
        prev_cs   = s_cs;
        prev_mosi = s_mosi;
    end

    task automatic clr_mon();
        rx_q.delete();
        rxc_q.delete();
        clk_rises = 0;
        cs_rises  = 0;
        mosi_bad  = 0;
        max_rxc   = 2'd0;
        mosi_bits = 16'h0;
    endtask

    task automatic send(input logic [7:0] b, input logic [1:0] cnt);
        int t = 0;
        while (!s_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", s_ready, 1'b1);
        tx_byte  = b;
        tx_count = cnt;
        tx_dv    = 1'b1;
        @(negedge clk);
        tx_dv    = 1'b0;
    endtask

    task automatic wait_cs_high(input int limit);
        int t = 0;
        while (!s_cs && t < limit) begin
            @(negedge clk);
            t++;
        end
        check("cs_rise", s_cs, 1'b1);
    endtask

    initial begin
        int g;
        int low_in_gap;
        clr_mon();
        repeat (3) @(negedge clk);
        check("rst_cs0", cs0, 1'b1);
        check("rst_clk0", sclk0, 1'b0);
        check("rst_clk3", sclk3, 1'b1);
        check("rst_mosi0", mosi0, 1'b0);
        check("rst_rx_dv", bus0.o_RX_DV, 1'b0);
        check("rst_rx_byte", bus0.o_RX_Byte, 8'h00);
        check("rst_rx_count", bus0.o_RX_Count, 2'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", s_ready, 1'b1);

        // Two-byte burst with an illegal 0xFF pulse while busy
        clr_mon();
        send(8'hC1, 2'd2);
        repeat (10) @(negedge clk);
        check("busy_not_ready", s_ready, 1'b0);
        tx_byte = 8'hFF;
        tx_dv   = 1'b1;
        @(negedge clk);
        tx_dv   = 1'b0;
        send(8'hC2, 2'd2);
        wait_cs_high(400);
        check("burst_rx_n", rx_q.size(), 2);
        check("burst_rx0", rx_q[0], 8'hC1);
        check("burst_rx1", rx_q[1], 8'hC2);
        check("burst_rxc0", rxc_q[0], 2'd0);
        check("burst_rxc1", rxc_q[1], 2'd1);
        check("burst_rxc_max", max_rxc, 2'd2);
        check("burst_sclk_rises", clk_rises, 16);
        check("burst_cs_rises", cs_rises, 1);
        check("burst_mosi", mosi_bits, 16'hC1C2);

        // Inter-burst gap
        g = 0;
        low_in_gap = 0;
        while (!s_ready && g < 100) begin
            if (!s_cs) low_in_gap++;
            @(negedge clk);
            g++;
        end
        check("gap_len_ge_10", (g >= 10), 1'b1);
        check("gap_cs_low", low_in_gap, 0);
        check("gap_rx_count_clr", s_rx_count, 2'd0);
        clr_mon();
        send(8'h5A, 2'd1);
        wait_cs_high(200);
        check("b3_rx", rx_q[0], 8'h5A);
        check("b3_rxc", rxc_q[0], 2'd0);

        // Single-byte burst
        clr_mon();
        send(8'hA5, 2'd1);
        wait_cs_high(200);
        check("single_rx_n", rx_q.size(), 1);
        check("single_rx", rx_q[0], 8'hA5);
        check("single_sclk_rises", clk_rises, 8);
        check("single_cs_rises", cs_rises, 1);

        // Count above maximum clamps to two bytes
        clr_mon();
        send(8'h12, 2'd3);
        send(8'h34, 2'd3);
        wait_cs_high(400);
        check("clamp_rx_n", rx_q.size(), 2);
        check("clamp_mosi", mosi_bits, 16'h1234);
        check("clamp_cs_rises", cs_rises, 1);

        // Reset in the middle of a byte
        clr_mon();
        send(8'h77, 2'd1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cs", s_cs, 1'b1);
        check("midrst_clk", s_clk, 1'b0);
        check("midrst_rx_dv", s_rx_dv, 1'b0);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("midrst_no_rx", rx_q.size(), 0);
        clr_mon();
        send(8'h81, 2'd0);
        wait_cs_high(200);
        check("post_rst_rx_n", rx_q.size(), 1);
        check("post_rst_rx", rx_q[0], 8'h81);
        repeat (15) @(negedge clk);

        // Mode 3
        sel = 1'b1;
        @(negedge clk);
        clr_mon();
        send(8'h3C, 2'd1);
        wait_cs_high(200);
        @(negedge clk);
        check("m3_rx_n", rx_q.size(), 1);
        check("m3_rx", rx_q[0], 8'h3C);
        check("m3_idle_clk", s_clk, 1'b1);
        check("m3_mosi_bits", mosi_bits[7:0], 8'h3C);
        check("m3_mosi_on_fall", mosi_bad, 0);
        check("m3_sclk_rises", clk_rises, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
